// File: rtl/disp_src_sched.sv
// disp_src_sched
//   Chooses what the two active front-panel digits show. There are three
//   sources, highest priority first: a latched error code (blinking), a
//   transient mode-change message, and the remaining wash time. The time
//   value is converted from binary minutes to BCD by a sequential
//   double-dabble engine.
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   time_val   remaining time in minutes (binary; values above 99 show as 99)
//   time_vld   1 = show the time digits, 0 = blank them
//   mode_req   pulse: show mode_code for HOLD_TICKS ticks
//   mode_code  mode number, sampled on mode_req
//   err_set    pulse: raise error err_code
//   err_code   error number, sampled on err_set
//   err_clr    pulse: clear the error
//   p1, p2     left/right digit codes to the scan driver (registered)
//   src        current source: 0 = time, 1 = mode, 2 = error (registered)
module disp_src_sched #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned HOLD_TICKS = 4,
  parameter logic [3:0]  BLANK      = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] time_val,
  input  logic       time_vld,
  input  logic       mode_req,
  input  logic [3:0] mode_code,
  input  logic       err_set,
  input  logic [3:0] err_code,
  input  logic       err_clr,
  output logic [3:0] p1,
  output logic [3:0] p2,
  output logic [1:0] src
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_TIME = 2'd0,
    S_MODE = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_pre;
  logic            r_blink;
  logic [HW-1:0]   r_hold;
  logic [3:0]      r_mode;
  logic [3:0]      r_err;
  logic            w_tick;
  logic            w_mode_acc;

  // double-dabble: [14:11] tens, [10:7] units, [6:0] binary being shifted in
  logic [14:0]     r_sh;
  logic [14:0]     w_adj;
  logic [14:0]     w_sh_next;
  logic [2:0]      r_iter;
  logic            r_busy;
  logic [6:0]      r_last;
  logic [6:0]      w_tclamp;
  logic [3:0]      r_tens;
  logic [3:0]      r_units;
  logic            r_bcd_ok;

  logic [3:0]      w_p1;
  logic [3:0]      w_p2;
  logic [1:0]      w_src;

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_mode_acc = mode_req && !err_set && (r_state != S_ERR);
  assign w_tclamp   = (time_val > 7'd99) ? 7'd99 : time_val;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_TIME;
    else      r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_TIME: begin
        if (err_set)       w_next = S_ERR;
        else if (mode_req) w_next = S_MODE;
      end
      S_MODE: begin
        if (err_set)                             w_next = S_ERR;
        else if (mode_req)                       w_next = S_MODE;
        else if (w_tick && r_hold == HOLD_LAST)  w_next = S_TIME;
      end
      S_ERR: begin
        if (err_set)      w_next = S_ERR;
        else if (err_clr) w_next = S_TIME;
      end
      default: w_next = S_TIME;
    endcase
  end

  // ---------------- FSM: output selection ----------------
  always_comb begin
    w_p1  = BLANK;
    w_p2  = BLANK;
    w_src = 2'd0;
    unique case (r_state)
      S_TIME: begin
        // r_bcd_ok keeps the reset-time zero from being shown as "00"
        if (time_vld && r_bcd_ok) begin
          w_p1 = r_tens;
          w_p2 = r_units;
        end
      end
      S_MODE: begin
        w_src = 2'd1;
        w_p2  = r_mode;
      end
      S_ERR: begin
        w_src = 2'd2;
        if (r_blink) begin
          w_p1 = 4'hE;
          w_p2 = r_err;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1  <= BLANK;
      p2  <= BLANK;
      src <= 2'd0;
    end else begin
      p1  <= w_p1;
      p2  <= w_p2;
      src <= w_src;
    end
  end

  // Prescaler and blink phase; an accepted error restarts both so the first
  // lit period is a full tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_blink <= 1'b1;
    end else if (err_set) begin
      r_pre   <= '0;
      r_blink <= 1'b1;
    end else if (w_tick) begin
      r_pre   <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_pre   <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      r_mode <= '0;
      r_err  <= '0;
    end else begin
      if (err_set) r_err <= err_code;
      if (w_mode_acc) begin
        r_mode <= mode_code;
        r_hold <= '0;
      end else if (r_state == S_MODE && w_tick && r_hold != HOLD_LAST) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  // ---------------- BCD converter ----------------
  always_comb begin
    w_adj = r_sh;
    if (r_sh[14:11] > 4'd4) w_adj[14:11] = r_sh[14:11] + 4'd3;
    if (r_sh[10:7]  > 4'd4) w_adj[10:7]  = r_sh[10:7]  + 4'd3;
  end
  assign w_sh_next = {w_adj[13:0], 1'b0};

  // Sample, 7 shift/add-3 steps, then commit on the 8th cycle so the
  // displayed digits only ever change to a finished result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh     <= '0;
      r_iter   <= '0;
      r_busy   <= 1'b0;
      r_last   <= 7'h7F;
      r_tens   <= '0;
      r_units  <= '0;
      r_bcd_ok <= 1'b0;
    end else if (!r_busy) begin
      if (w_tclamp != r_last) begin
        r_last <= w_tclamp;
        r_sh   <= {8'h00, w_tclamp};
        r_iter <= '0;
        r_busy <= 1'b1;
      end
    end else if (r_iter != 3'd7) begin
      r_sh   <= w_sh_next;
      r_iter <= r_iter + 3'd1;
    end else begin
      r_tens   <= r_sh[14:11];
      r_units  <= r_sh[10:7];
      r_bcd_ok <= 1'b1;
      r_busy   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_src_sched.sv
module tb_disp_src_sched;

  localparam int TD = 4;
  localparam int HT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] time_val = '0;
  logic       time_vld = 1'b0;
  logic       mode_req = 1'b0;
  logic [3:0] mode_code = '0;
  logic       err_set = 1'b0;
  logic [3:0] err_code = '0;
  logic       err_clr = 1'b0;
  logic [3:0] p1, p2;
  logic [1:0] src;

  int n_tests = 0;
  int n_fail  = 0;

  disp_src_sched #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLANK(4'hF)) dut (
    .clk(clk), .rst(rst), .time_val(time_val), .time_vld(time_vld),
    .mode_req(mode_req), .mode_code(mode_code), .err_set(err_set),
    .err_code(err_code), .err_clr(err_clr), .p1(p1), .p2(p2), .src(src)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // source: 0 time, 1 mode, 2 error; conversion modelled as "value lands
  // 8 cycles after being picked up, next pick-up only after that".
  int m_src, m_pre, m_blink, m_hold, m_mode, m_err;
  int m_last, m_left, m_val, m_tens, m_units, m_clamp;
  bit m_ok, m_tick;
  logic [3:0] e_p1 = 4'hF, e_p2 = 4'hF;
  logic [1:0] e_src = 2'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_src = 0; m_pre = 0; m_blink = 1; m_hold = 0; m_mode = 0; m_err = 0;
      m_last = 127; m_left = 0; m_val = 0; m_tens = 0; m_units = 0; m_ok = 0;
      e_p1 = 4'hF; e_p2 = 4'hF; e_src = 2'd0;
    end else begin
      // registered outputs show what the pre-edge state selects
      e_p1 = 4'hF; e_p2 = 4'hF; e_src = 2'(m_src);
      if (m_src == 0 && time_vld && m_ok) begin
        e_p1 = 4'(m_tens); e_p2 = 4'(m_units);
      end else if (m_src == 1) begin
        e_p2 = 4'(m_mode);
      end else if (m_src == 2 && m_blink == 1) begin
        e_p1 = 4'hE; e_p2 = 4'(m_err);
      end
      m_tick  = (m_pre == TD - 1);
      m_clamp = (int'(time_val) > 99) ? 99 : int'(time_val);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_tens = m_val / 10; m_units = m_val % 10; m_ok = 1;
        end
      end else if (m_clamp != m_last) begin
        m_last = m_clamp; m_val = m_clamp; m_left = 8;
      end
      if (err_set) begin
        m_err = int'(err_code); m_src = 2; m_pre = 0; m_blink = 1;
      end else begin
        if (m_tick) begin m_pre = 0; m_blink = 1 - m_blink; end
        else m_pre++;
        case (m_src)
          0: if (mode_req) begin m_src = 1; m_mode = int'(mode_code); m_hold = 0; end
          1: begin
            if (mode_req) begin m_mode = int'(mode_code); m_hold = 0; end
            else if (m_tick) begin
              if (m_hold == HT - 1) m_src = 0;
              else m_hold++;
            end
          end
          default: if (err_clr) m_src = 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    n_tests++;
    if (p1 !== e_p1 || p2 !== e_p2 || src !== e_src) begin
      n_fail++;
      $display("FAIL model t=%0t: p1/p2/src got %h %h %0d, expected %h %h %0d",
               $time, p1, p2, src, e_p1, e_p2, e_src);
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_lit(input string name, input logic [3:0] x1,
                         input logic [3:0] x2, input logic [1:0] xs);
    n_tests++;
    if (p1 !== x1 || p2 !== x2 || src !== xs) begin
      n_fail++;
      $display("FAIL %s: got %h %h src %0d, expected %h %h src %0d",
               name, p1, p2, src, x1, x2, xs);
    end
  endtask

  task automatic wait_disp(input string name, input logic [3:0] x1,
                           input logic [3:0] x2, input logic [1:0] xs,
                           input int maxc);
    int k = 0;
    while (!(p1 === x1 && p2 === x2 && src === xs) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk_lit(name, x1, x2, xs);
  endtask

  task automatic pulse_mode(input logic [3:0] c);
    mode_req = 1'b1; mode_code = c;
    step(1);
    mode_req = 1'b0;
  endtask

  task automatic pulse_err(input logic [3:0] c);
    err_set = 1'b1; err_code = c;
    step(1);
    err_set = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst = 1'b0;
    step(3);
    chk_lit("reset", 4'hF, 4'hF, 2'd0);

    // 1: conversion, clamp, blanking
    rst = 1'b1; time_vld = 1'b1; time_val = 7'd47;
    step(1);
    chk_lit("pre_conv_blank", 4'hF, 4'hF, 2'd0);
    wait_disp("conv_47", 4'd4, 4'd7, 2'd0, 10);
    time_val = 7'd120;
    wait_disp("clamp_99", 4'd9, 4'd9, 2'd0, 12);
    time_vld = 1'b0;
    step(2);
    chk_lit("vld_blank", 4'hF, 4'hF, 2'd0);
    time_vld = 1'b1; time_val = 7'd47;
    wait_disp("conv_47b", 4'd4, 4'd7, 2'd0, 12);

    // 2: mode message and hold restart
    pulse_mode(4'd3);
    step(1);
    chk_lit("mode_show", 4'hF, 4'd3, 2'd1);
    step(6);
    chk_lit("mode_hold", 4'hF, 4'd3, 2'd1);
    wait_disp("mode_expire", 4'd4, 4'd7, 2'd0, 16);
    pulse_mode(4'd3);
    step(5);
    pulse_mode(4'd5);
    step(1);
    chk_lit("mode_relatch", 4'hF, 4'd5, 2'd1);
    step(7);
    chk_lit("mode_restart", 4'hF, 4'd5, 2'd1);
    wait_disp("mode_expire2", 4'd4, 4'd7, 2'd0, 16);

    // 3: error during mode, blink cadence, clear
    pulse_mode(4'd3);
    step(3);
    pulse_err(4'd2);
    step(1);
    chk_lit("err_lit_first", 4'hE, 4'd2, 2'd2);
    step(3);
    chk_lit("err_lit_last", 4'hE, 4'd2, 2'd2);
    step(1);
    chk_lit("err_dark_first", 4'hF, 4'hF, 2'd2);
    step(3);
    chk_lit("err_dark_last", 4'hF, 4'hF, 2'd2);
    step(1);
    chk_lit("err_relit", 4'hE, 4'd2, 2'd2);
    pulse_clr();
    step(1);
    chk_lit("err_clear", 4'd4, 4'd7, 2'd0);

    // 4: simultaneous requests
    mode_req = 1'b1; mode_code = 4'd1;
    pulse_err(4'd6);
    mode_req = 1'b0;
    step(1);
    chk_lit("err_over_mode", 4'hE, 4'd6, 2'd2);
    step(3);
    err_clr = 1'b1;
    pulse_err(4'd9);
    err_clr = 1'b0;
    step(1);
    chk_lit("set_over_clr", 4'hE, 4'd9, 2'd2);
    step(3);
    chk_lit("set_blink_restart", 4'hE, 4'd9, 2'd2);
    step(1);
    chk_lit("set_blink_dark", 4'hF, 4'hF, 2'd2);
    pulse_mode(4'd4);
    step(2);
    chk_lit("mode_ignored_in_err", 4'hF, 4'hF, 2'd2);
    pulse_clr();
    step(1);
    chk_lit("clr_back_time", 4'd4, 4'd7, 2'd0);

    // 5: time changes while error shown
    time_val = 7'd12;
    wait_disp("conv_12", 4'd1, 4'd2, 2'd0, 12);
    pulse_err(4'd7);
    time_val = 7'd34;
    step(12);
    pulse_clr();
    step(1);
    chk_lit("fresh_after_clr", 4'd3, 4'd4, 2'd0);

    // 6: asynchronous reset mid-error and mid-conversion
    pulse_err(4'd5);
    step(2);
    time_val = 7'd88;
    step(3);
    #2 rst = 1'b0;
    #1 chk_lit("async_reset", 4'hF, 4'hF, 2'd0);
    step(2);
    rst = 1'b1;
    step(1);
    chk_lit("post_reset_blank", 4'hF, 4'hF, 2'd0);
    wait_disp("reconv_88", 4'd8, 4'd8, 2'd0, 12);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_src_sched.md
Name: disp_src_sched

Overview:
- Decides what the two active 7-segment digits show on the washing-machine front panel.
- Its outputs p1/p2 (one 4-bit digit code each) drive the display scan driver directly.
- Three sources share the display in fixed priority: latched error code, transient mode-change message, remaining-time countdown.
- Remaining time arrives as a binary minute count and is converted to two BCD digits by a sequential double-dabble engine.

Parameters:
- TICK_DIV, 25000000: clk cycles per tick (0.5 s at 50 MHz); tick paces the blink and hold timers.
- HOLD_TICKS, 4: number of ticks a mode message stays on the display.
- BLANK, 4'hF: digit code the scan decoder renders as all segments off.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- time_val  in  7  remaining wash time in minutes, binary.
- time_vld  in  1  1 = timer running and time is shown; 0 = time digits blank.
- mode_req  in  1  one-cycle pulse: show mode_code.
- mode_code  in  4  mode number, sampled on mode_req.
- err_set  in  1  one-cycle pulse: raise error err_code.
- err_code  in  4  error number, sampled on err_set.
- err_clr  in  1  one-cycle pulse: clear the error.
- p1  out  4  tens/left digit code to the scan driver.
- p2  out  4  units/right digit code to the scan driver.
- src  out  2  current source: 0 = time, 1 = mode, 2 = error.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = S_TIME; p1 = p2 = BLANK; src = 0.
  - Prescaler and hold counter = 0; blink phase = 1.
  - BCD result = 0; last-converted register = 7'h7F, which forces a conversion on the first cycle after reset.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick is a one-cycle pulse on wrap.
  - Blink phase toggles on each tick.
- BCD converter:
  - When idle and the clamped time_val differs from the last converted value, it samples the value. Clamp: time_val > 99 is treated as 99.
  - Runs 7 shift/add-3 iterations, one per clk.
  - Tens/units registers update 8 cycles after the sample.
  - Changes to time_val while busy are ignored until idle, then re-sampled.
  - Displayed time never shows a partial conversion.
- Outputs are registered: p1/p2/src reflect the state/data of the previous cycle (1-cycle latency).
- S_TIME (src=0):
  - p1 = tens, p2 = units when time_vld = 1; otherwise p1 = p2 = BLANK.
  - err_set -> S_ERR, latch err_code.
  - Otherwise mode_req -> S_MODE, latch mode_code, hold counter = 0.
- S_MODE (src=1):
  - p1 = BLANK, p2 = latched mode code.
  - Hold counter increments on tick; a tick with hold counter = HOLD_TICKS-1 -> S_TIME.
  - A new mode_req re-latches the code and restarts the hold counter at 0.
  - err_set -> S_ERR and takes priority over mode_req and the hold expiry; the pending mode message is discarded.
- S_ERR (src=2):
  - Blink phase 1: p1 = 4'hE, p2 = latched err code. Blink phase 0: p1 = p2 = BLANK.
  - On entry (and on every err_set while already in S_ERR): blink phase forced to 1 and prescaler cleared, so the first lit period is a full TICK_DIV.
  - err_clr -> S_TIME.
  - err_set together with err_clr: set wins; stay in S_ERR and re-latch the code.
  - mode_req is ignored and not queued.
- Simultaneous err_set + mode_req in any state -> S_ERR.
- time_vld, time_val changes and the converter continue in every state; after returning to S_TIME the display shows the latest completed conversion.

Test Plan:
- Bench parameters: TICK_DIV=4, HOLD_TICKS=3.
1. Release reset, time_vld=1, time_val=47 -> p1=F,p2=F until the conversion completes; p1=4,p2=7,src=0 within 10 cycles. Then time_val=120 -> 9,9. Then time_vld=0 -> F,F.
2. In S_TIME with 4,7 shown, mode_req with mode_code=3 -> next cycle src=1,p1=F,p2=3. Exactly 3 ticks later (12 cycles ±prescaler phase) back to 4,7, src=0. A second mode_req with code 5 mid-hold -> shows 5 and the hold restarts.
3. err_set with code 2 during S_MODE -> src=2, E,2 for 4 cycles, F,F for 4 cycles, repeating. err_clr -> time digits shown, src=0.
4. Same-cycle err_set(code 6) + mode_req -> src=2, E,6. In S_ERR, same-cycle err_set(code 9) + err_clr -> stays src=2 showing E,9 with blink restarted lit.
5. Change time_val 12->34 during S_ERR -> after err_clr the display shows 3,4 immediately, with no stale 1,2.
6. Drive rst=0 asynchronously mid-S_ERR and mid-conversion -> p1=F,p2=F,src=0 without waiting for clk. After release, a fresh conversion of the current time_val completes and is displayed.
